// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one shared memory; data wins collisions unless fetch has starved.
// Latency: gnt at T, mem_en at T+1, rvalid at T+1+MEM_LATENCY; one transaction outstanding.
module mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [DATA_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [2:0]            d_funct3,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int LW = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state;
    logic [SW-1:0] starve;
    logic [LW-1:0] cnt;
    logic          owner_data;
    logic          owner_wr;
    logic          fetch_wins;
    logic          last_wait;

    assign fetch_wins = (starve == SW'(STARVE_LIMIT));

    // Grants are gated by rst so outputs stay low during reset even with requests held.
    assign i_gnt = rst && (state == IDLE) && i_req && (!d_req || fetch_wins);
    assign d_gnt = rst && (state == IDLE) && d_req && !(i_req && fetch_wins);

    assign busy      = (state != IDLE);
    assign last_wait = (state == WAIT) && (cnt == LW'(MEM_LATENCY - 1));
    assign i_rvalid  = last_wait && !owner_data;
    assign d_rvalid  = last_wait && owner_data;
    assign i_rdata   = i_rvalid ? mem_rdata : '0;
    assign d_rdata   = (d_rvalid && !owner_wr) ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve     <= '0;
            cnt        <= '0;
            owner_data <= 1'b0;
            owner_wr   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_funct3 <= 3'b000;
        end else begin
            // The mem_* registers double as the captured request; they are live only in ISSUE.
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_funct3 <= 3'b000;
            case (state)
                IDLE: begin
                    if (i_gnt || !i_req) begin
                        starve <= '0;
                    end else if (d_req && !fetch_wins) begin
                        starve <= starve + SW'(1);
                    end
                    if (d_gnt) begin
                        state      <= ISSUE;
                        owner_data <= 1'b1;
                        owner_wr   <= d_we;
                        mem_en     <= 1'b1;
                        mem_we     <= d_we;
                        mem_addr   <= d_addr;
                        mem_wdata  <= d_wdata;
                        mem_funct3 <= d_funct3;
                    end else if (i_gnt) begin
                        state      <= ISSUE;
                        owner_data <= 1'b0;
                        owner_wr   <= 1'b0;
                        mem_en     <= 1'b1;
                        mem_addr   <= i_addr;
                        mem_funct3 <= 3'b010;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: begin
                    if (cnt == LW'(MEM_LATENCY - 1)) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + LW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: queued requests, behavioural memory, per-cycle expected outputs.
module tb_mem_arbiter;
    localparam int LAT  = 2;
    localparam int SLIM = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [2:0]  d_funct3 = '0;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [2:0]  mem_funct3;

    mem_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [2:0] f3; } dop_t;
    typedef struct { logic own_d; logic [31:0] dat; int due; } resp_t;

    logic [31:0] iq[$];
    dop_t        dq[$];
    resp_t       sb[$];

    int n_vec = 0, n_bad = 0;
    int cyc = 0;
    int busy_from = 0, free_cyc = 0, starve = 0;
    int men_cyc = -100, rd_cyc = -100, last_g = -1, ig_cyc = -1, irv_cyc = -1;
    logic        gap_en = 1'b0;
    logic        m_we;
    logic [31:0] m_addr, m_wd, rd_addr;
    logic [2:0]  m_f3;
    string       ord = "";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] memfun(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : ((a ^ 32'h5A5A_0000) + 32'h1357);
    endfunction

    // Drive after the rising edge, model/check after the falling edge.
    initial begin : engine
        logic  exp_busy, e_ig, e_dg, e_men;
        resp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (iq.size() > 0) begin i_req = 1'b1; i_addr = iq[0]; end
            else begin i_req = 1'b0; i_addr = '0; end
            if (dq.size() > 0) begin
                d_req = 1'b1; d_we = dq[0].we; d_addr = dq[0].addr;
                d_wdata = dq[0].wdata; d_funct3 = dq[0].f3;
            end else begin
                d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_funct3 = '0;
            end
            @(negedge clk);
            mem_rdata = (rd_cyc + LAT == cyc) ? memfun(rd_addr) : (32'hA5A5_0000 ^ 32'(cyc));
            #1;
            if (!rst) begin
                busy_from = 0; free_cyc = 0; starve = 0; sb.delete();
                men_cyc = -100; rd_cyc = -100; last_g = -1;
            end else begin
                exp_busy = (cyc >= busy_from) && (cyc < free_cyc);
                e_ig = !exp_busy && i_req && (!d_req || starve == SLIM);
                e_dg = !exp_busy && d_req && !(i_req && starve == SLIM);
                chk("i_gnt", i_gnt, e_ig);
                chk("d_gnt", d_gnt, e_dg);
                chk("busy", busy, exp_busy);
                e_men = (men_cyc == cyc);
                chk("mem_en", mem_en, e_men);
                chk("mem_we", mem_we, e_men ? m_we : 1'b0);
                chk("mem_addr", mem_addr, e_men ? m_addr : 32'h0);
                chk("mem_wdata", mem_wdata, e_men ? m_wd : 32'h0);
                chk("mem_funct3", mem_funct3, e_men ? m_f3 : 3'b000);
                if (mem_en) begin rd_cyc = cyc; rd_addr = mem_addr; end
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    chk("i_rvalid", i_rvalid, !e.own_d);
                    chk("d_rvalid", d_rvalid, e.own_d);
                    chk("i_rdata", i_rdata, e.own_d ? 32'h0 : e.dat);
                    chk("d_rdata", d_rdata, e.own_d ? e.dat : 32'h0);
                end else begin
                    chk("i_rvalid_idle", i_rvalid, 1'b0);
                    chk("d_rvalid_idle", d_rvalid, 1'b0);
                    chk("i_rdata_idle", i_rdata, 32'h0);
                    chk("d_rdata_idle", d_rdata, 32'h0);
                end
                if (i_gnt) begin ord = {ord, "I"}; ig_cyc = cyc; end
                if (d_gnt) ord = {ord, "D"};
                if (i_rvalid) irv_cyc = cyc;
                if ((i_gnt || d_gnt) && gap_en && last_g >= 0) chk("gnt_gap", cyc - last_g, LAT + 2);
                if (i_gnt || d_gnt) last_g = cyc;
                if (e_ig || e_dg) begin
                    busy_from = cyc + 1; free_cyc = cyc + LAT + 2; men_cyc = cyc + 1;
                    m_we   = e_dg ? d_we : 1'b0;
                    m_addr = e_dg ? d_addr : i_addr;
                    m_wd   = e_dg ? d_wdata : 32'h0;
                    m_f3   = e_dg ? d_funct3 : 3'b010;
                    sb.push_back('{e_dg, e_dg ? (d_we ? 32'h0 : memfun(d_addr)) : memfun(i_addr),
                                   cyc + 1 + LAT});
                end
                if (!exp_busy) begin
                    if (e_ig || !i_req) starve = 0;
                    else if (d_req && starve < SLIM) starve++;
                end
                if (i_gnt && iq.size() > 0) void'(iq.pop_front());
                if (d_gnt && dq.size() > 0) void'(dq.pop_front());
            end
        end
    end

    task automatic wait_idle();
        logic done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(posedge clk);
            if (iq.size() == 0 && dq.size() == 0 && sb.size() == 0 && cyc >= free_cyc) done = 1'b1;
        end
        chk("idle_timeout", done, 1'b1);
    endtask

    initial begin : main
        logic got;
        // Reset with both requests pending: everything quiet.
        iq.push_back(32'h20);
        dq.push_back('{1'b0, 32'h80, 32'h0, 3'b010});
        repeat (2) @(posedge clk);
        #3;
        chk("rst_req_held", {30'h0, i_req, d_req}, 32'h3);
        chk("rst_i_gnt", i_gnt, 1'b0);
        chk("rst_d_gnt", d_gnt, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_i_rvalid", i_rvalid, 1'b0);
        chk("rst_d_rvalid", d_rvalid, 1'b0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        // Release: collision resolves data first, fetch on the next idle cycle.
        ord = "";
        @(posedge clk);
        #2 rst = 1'b1;
        wait_idle();
        chk("order_collide", (ord == "DI"), 1'b1);

        // Single fetch read at 0x10.
        ig_cyc = -1; irv_cyc = -1;
        iq.push_back(32'h10);
        wait_idle();
        chk("fetch_lat", irv_cyc - ig_cyc, LAT + 1);

        // Data write.
        dq.push_back('{1'b1, 32'h100, 32'h12345678, 3'b000});
        wait_idle();

        // Continuous contention: fetch forced through after SLIM data wins.
        ord = ""; last_g = -1; gap_en = 1'b1;
        for (int k = 0; k < 6; k++) dq.push_back('{1'b0, 32'h200 + 32'(4 * k), 32'h0, 3'b010});
        iq.push_back(32'h300);
        iq.push_back(32'h304);
        wait_idle();
        gap_en = 1'b0;
        chk("order_starve", (ord == "DDDDIDDI"), 1'b1);

        // Random mix.
        for (int k = 0; k < 5; k++) iq.push_back($urandom & 32'hFFFC);
        for (int k = 0; k < 7; k++)
            dq.push_back('{1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7))});
        wait_idle();

        // Reset in the second cycle of a fetch read abandons it.
        ig_cyc = -1;
        iq.push_back(32'h40);
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            #2;
            if (ig_cyc >= 0) got = 1'b1;
        end
        chk("mid_gnt_seen", got, 1'b1);
        irv_cyc = -1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_mem_en", mem_en, 1'b0);
        chk("mid_rst_i_rvalid", i_rvalid, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        repeat (8) @(posedge clk);
        chk("mid_no_rvalid", irv_cyc, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; ports clk and rst (rst low = reset).
REQ-002 Parameters SHALL be: DATA_WIDTH, default 32, data/address width; MEM_LATENCY, default 2, cycles from mem_en to valid mem_rdata (legal range >=1); STARVE_LIMIT, default 4, consecutive fetch losses before fetch is forced to win (legal range >=1).
REQ-003 Ports SHALL be (name  direction  width  meaning):
clk  in  1  clock
rst  in  1  async active-low reset
i_req  in  1  fetch request, held until i_gnt
i_addr  in  DATA_WIDTH  fetch address
i_gnt  out  1  fetch request accepted this cycle
i_rvalid  out  1  fetch data valid, 1-cycle pulse
i_rdata  out  DATA_WIDTH  fetch read data
d_req  in  1  data request, held until d_gnt
d_we  in  1  data write enable
d_addr  in  DATA_WIDTH  data address
d_wdata  in  DATA_WIDTH  data write value
d_funct3  in  3  access size/sign code, passed through to memory
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  data read data / write ack, 1-cycle pulse
d_rdata  out  DATA_WIDTH  data read data
mem_en  out  1  shared memory access strobe
mem_we  out  1  shared memory write enable
mem_addr  out  DATA_WIDTH  shared memory address
mem_wdata  out  DATA_WIDTH  shared memory write data
mem_funct3  out  3  shared memory access code
mem_rdata  in  DATA_WIDTH  shared memory read data
busy  out  1  transaction in flight

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT; busy SHALL be 1 in ISSUE and WAIT and 0 in IDLE.
REQ-005 In IDLE with any request, exactly one gnt SHALL assert combinationally that cycle; the FSM SHALL enter ISSUE next cycle.
REQ-006 The arbiter SHALL grant data over fetch on simultaneous requests, unless the starvation counter equals STARVE_LIMIT, in which case fetch SHALL win.
REQ-007 The starvation counter SHALL increment (saturating at STARVE_LIMIT) on each IDLE cycle with i_req and d_req both high where data wins; it SHALL clear on i_gnt and in any IDLE cycle with i_req low.
REQ-008 On grant, the winner's address, write data, we and funct3 SHALL be registered; for fetch, mem_we=0, mem_wdata=0 and mem_funct3=3'b010.
REQ-009 In ISSUE, mem_en SHALL be 1 for exactly one cycle with the registered fields on mem_*; mem_* SHALL be 0 in all other cycles.
REQ-010 WAIT SHALL last MEM_LATENCY cycles; in its last cycle the owner's rvalid SHALL pulse and its rdata SHALL equal mem_rdata sampled that cycle; the FSM SHALL return to IDLE next cycle.
REQ-011 For data writes, d_rvalid SHALL pulse at the same cycle as a read would, with d_rdata=0.
REQ-012 rdata outputs SHALL be 0 whenever the corresponding rvalid is 0.
REQ-013 No gnt SHALL assert outside IDLE; requests arriving in ISSUE/WAIT SHALL wait; one transaction is outstanding at most.
REQ-014 Transaction latency SHALL be gnt at T, mem_en at T+1, rvalid at T+1+MEM_LATENCY; back-to-back grants SHALL be MEM_LATENCY+2 cycles apart.

Reset
REQ-015 While rst is low, state SHALL be IDLE, starvation counter 0, and all outputs 0, independent of clk.
REQ-016 Reset asserted in ISSUE or WAIT SHALL abandon the transaction: no rvalid SHALL pulse for it after release.
REQ-017 After rst rises, the first grant SHALL be possible on the first clk edge window in IDLE.

Verification
REQ-018 Reset: rst low with i_req=d_req=1 -> all outputs 0, busy 0.
REQ-019 Fetch read, MEM_LATENCY=2: i_req, i_addr=0x10 at cycle 0 -> i_gnt cycle 0; mem_en=1, mem_addr=0x10, mem_we=0 cycle 1; mem_rdata=0xDEADBEEF cycle 3 -> i_rvalid=1, i_rdata=0xDEADBEEF cycle 3; i_gnt possible again cycle 4.
REQ-020 Collision: i_req and d_req rise together, counter 0 -> d_gnt first; i_gnt at the next IDLE cycle if d_req is dropped.
REQ-021 Starvation, STARVE_LIMIT=4: i_req and d_req held high continuously -> grant order D,D,D,D,I,D,...
REQ-022 Data write: d_we=1, d_addr=0x100, d_wdata=0x12345678, d_funct3=3'b000 -> mem_we=1, mem_wdata=0x12345678, mem_funct3=3'b000 at cycle 1; d_rvalid=1, d_rdata=0 at cycle 3.
REQ-023 Reset mid-transaction: rst low in cycle 2 of a fetch read -> busy 0 immediately; no i_rvalid in any later cycle for that request.
